dmem_ctrl: RTL and testbench

Parametrised, byte-addressed, little-endian data memory for the pipeline's MEM stage, with a valid/ready request port and a registered response port. It replaces the combinational word memory with a synchronous array, adds true byte-lane stores, RISC-V-correct load extension, misalign/range error reporting, a configurable wait-state model and a post-reset clear sequence. The pipeline stalls on `req_ready` low and consumes `resp_*` as the load-writeback source.

---
 rtl/dmem_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data memory with a valid/ready request port,
// registered response, RISC-V load extension, error reporting, wait states and post-reset clear.
module dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter bit INIT_CLEAR  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    init_cnt_q, init_cnt_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem_q [DEPTH_WORDS];
  logic                mem_we;
  logic [3:0]          mem_be;
  logic [IDX_W-1:0]    mem_idx;
  logic [31:0]         mem_wdata;

  logic                accept, op_go, use_req;
  logic                op_we, op_err;
  logic [2:0]          op_f3;
  logic [ADDR_W-1:0]   op_addr;
  logic [31:0]         op_wdata, rd_word, ld_data;
  logic [1:0]          lane;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;

  assign req_ready  = (state_q == S_IDLE) || (state_q == S_RESP);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_go      = 1'b0;
    use_req    = 1'b0;
    case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + IDX_W'(1);
        if (init_cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d    = S_IDLE;
          init_cnt_d = '0;
        end
      end
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: the operation happens on the accept edge itself.
            state_d = S_RESP;
            op_go   = 1'b1;
            use_req = 1'b1;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd1) begin
          state_d = S_RESP;
          op_go   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_we    = use_req ? req_we     : we_q;
    op_f3    = use_req ? req_funct3 : f3_q;
    op_addr  = use_req ? req_addr   : addr_q;
    op_wdata = use_req ? req_wdata  : wdata_q;
    lane     = op_addr[1:0];
    idx      = op_addr[IDX_W+1:2];
    rd_word  = mem_q[idx];
    rd_byte  = 8'(rd_word >> {lane, 3'b000});
    rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (op_f3)
      3'b000:  op_err = 1'b0;
      3'b001:  op_err = op_addr[0];
      3'b010:  op_err = |op_addr[1:0];
      3'b100:  op_err = op_we;
      3'b101:  op_err = op_we | op_addr[0];
      default: op_err = 1'b1;
    endcase
    if (op_addr[ADDR_W-1:2] >= DEPTH_LIM) op_err = 1'b1;

    case (op_f3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_data = {16'd0, rd_half};
      default: ld_data = rd_word;
    endcase

    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_idx   = idx;
    mem_wdata = 32'd0;
    if (state_q == S_INIT) begin
      mem_we  = 1'b1;
      mem_be  = 4'b1111;
      mem_idx = init_cnt_q;
    end else if (op_go && op_we && !op_err) begin
      mem_we = 1'b1;
      case (op_f3)
        3'b000: begin
          mem_be    = 4'b0001 << lane;
          mem_wdata = {4{op_wdata[7:0]}};
        end
        3'b001: begin
          mem_be    = lane[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{op_wdata[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = op_wdata;
        end
      endcase
    end
    // A reset edge must never commit a pending store.
    mem_we = mem_we && rst_n;

    rdata_d = rdata_q;
    err_d   = err_q;
    if (op_go) begin
      rdata_d = (op_err || op_we) ? 32'd0 : ld_data;
      err_d   = op_err;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT_CLEAR ? S_INIT : S_IDLE;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the array has no reset; clearing is done one word per cycle by the INIT sequence.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: instance 0 has no wait states, instance 1 has three.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err [2];

  int compared   = 0;
  int mismatched = 0;

  dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(16), .WAIT_CYCLES(0), .INIT_CLEAR(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(16), .WAIT_CYCLES(3), .INIT_CLEAR(1'b1)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
  endtask

  // One complete transaction; returns at the negedge where resp_valid is seen.
  task automatic xact(input int d, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    drive(d, we, f3, addr, wdata);
    n = 0;
    while (!req_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_within_bound", 32'(n < 200), 32'd1);
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 0;
    while (!resp_valid[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("resp_within_bound", 32'(n < 50), 32'd1);
    rdata = resp_rdata[d];
    err   = resp_err[d];
  endtask

  task automatic ld_chk(input string tag, input int d, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    xact(d, 1'b0, f3, addr, 32'd0, rd, er);
    check({tag, "_rdata"}, rd, exp_data);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  task automatic st_chk(input string tag, input int d, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    xact(d, 1'b1, f3, addr, wdata, rd, er);
    check({tag, "_rdata"}, rd, 32'd0);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  initial begin
    int n;
    int n_valid;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_funct3[d] = 3'b000;
      req_addr[d]   = 32'd0;
      req_wdata[d]  = 32'd0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready",  32'(req_ready[0]),  32'd0);
    check("rst_valid",  32'(resp_valid[0]), 32'd0);
    check("rst_rdata",  resp_rdata[0],      32'd0);
    check("rst_err",    32'(resp_err[0]),   32'd0);
    check("rst_valid3", 32'(resp_valid[1]), 32'd0);

    // INIT: ready stays low for DEPTH_WORDS cycles after release
    rst_n = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("init_low_cycles", 32'(n), 32'd16);
    check("init_ready3", 32'(req_ready[1]), 32'd1);
    ld_chk("init_lw_3c", 0, 3'b010, 32'h3C, 32'h0000_0000, 1'b0);

    // Byte lanes
    st_chk("sw_8",  0, 3'b010, 32'h8, 32'h1122_3344, 1'b0);
    st_chk("sb_a",  0, 3'b000, 32'hA, 32'h0000_00AA, 1'b0);
    st_chk("sh_8",  0, 3'b001, 32'h8, 32'h0000_BEEF, 1'b0);
    ld_chk("lw_8",  0, 3'b010, 32'h8, 32'h11AA_BEEF, 1'b0);
    ld_chk("lb_a",  0, 3'b000, 32'hA, 32'hFFFF_FFAA, 1'b0);
    ld_chk("lbu_a", 0, 3'b100, 32'hA, 32'h0000_00AA, 1'b0);
    ld_chk("lh_8",  0, 3'b001, 32'h8, 32'hFFFF_BEEF, 1'b0);
    ld_chk("lhu_8", 0, 3'b101, 32'h8, 32'h0000_BEEF, 1'b0);
    ld_chk("lhu_a", 0, 3'b101, 32'hA, 32'h0000_11AA, 1'b0);
    ld_chk("lb_b",  0, 3'b000, 32'hB, 32'h0000_0011, 1'b0);

    // Errors
    ld_chk("err_lw_2",   0, 3'b010, 32'h2,  32'd0, 1'b1);
    st_chk("sw_4",       0, 3'b010, 32'h4,  32'h5566_7788, 1'b0);
    st_chk("err_sh_5",   0, 3'b001, 32'h5,  32'h0000_1234, 1'b1);
    ld_chk("lw_4_kept",  0, 3'b010, 32'h4,  32'h5566_7788, 1'b0);
    ld_chk("err_lw_40",  0, 3'b010, 32'h40, 32'd0, 1'b1);
    ld_chk("err_f3_011", 0, 3'b011, 32'h0,  32'd0, 1'b1);
    st_chk("err_sbu",    0, 3'b100, 32'h4,  32'h0000_0099, 1'b1);
    ld_chk("lw_4_kept2", 0, 3'b010, 32'h4,  32'h5566_7788, 1'b0);

    // Back-to-back store then load, no wait states
    @(negedge clk);
    drive(0, 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D);
    check("b2b_ready_a", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    check("b2b_valid_a", 32'(resp_valid[0]), 32'd1);
    check("b2b_store_rdata", resp_rdata[0], 32'd0);
    check("b2b_ready_b", 32'(req_ready[0]), 32'd1);
    drive(0, 1'b0, 3'b010, 32'h10, 32'd0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("b2b_valid_b", 32'(resp_valid[0]), 32'd1);
    check("b2b_load_rdata", resp_rdata[0], 32'hCAFE_F00D);
    check("b2b_load_err", 32'(resp_err[0]), 32'd0);
    @(negedge clk);
    check("b2b_idle_valid", 32'(resp_valid[0]), 32'd0);
    check("b2b_hold_rdata", resp_rdata[0], 32'hCAFE_F00D);

    // Wait states: accept in cycle t, response in cycle t+4
    @(negedge clk);
    drive(1, 1'b1, 3'b010, 32'h0, 32'hA5A5_A5A5);
    check("ws_ready_t", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("ws_ready_t%0d", k), 32'(req_ready[1]), 32'd0);
      check($sformatf("ws_valid_t%0d", k), 32'(resp_valid[1]), 32'd0);
      @(negedge clk);
    end
    check("ws_valid_t4", 32'(resp_valid[1]), 32'd1);
    check("ws_ready_t4", 32'(req_ready[1]), 32'd1);
    ld_chk("ws_lw_0", 1, 3'b010, 32'h0, 32'hA5A5_A5A5, 1'b0);

    // Reset while a store is waiting
    @(negedge clk);
    drive(1, 1'b1, 3'b010, 32'h4, 32'h1234_5678);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("rm_in_wait", 32'(req_ready[1]), 32'd0);
    rst_n = 1'b0;
    n_valid = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid[1]) n_valid++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid[1]) n_valid++;
    end
    check("rm_no_resp", 32'(n_valid), 32'd0);
    ld_chk("rm_lw_4",  1, 3'b010, 32'h4,  32'd0, 1'b0);
    ld_chk("rm_lw_0",  1, 3'b010, 32'h0,  32'd0, 1'b0);
    ld_chk("rm_dut0_lw_8", 0, 3'b010, 32'h8, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
